// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings, display codes and helpers for the game status formatter
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2,
        ST_QUIT = 2'd3
    } state_t;

    // Digit code the seven-segment decoder renders as an unlit digit
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Mode codes shown on HEX0
    localparam logic [3:0] MODE_IDLE = 4'h0;
    localparam logic [3:0] MODE_PLAY = 4'h1;
    localparam logic [3:0] MODE_OVER = 4'hE;
    localparam logic [3:0] MODE_QUIT = 4'hC;

    localparam logic [9:0] LEDR_ALL = 10'h3FF;

    // Thermometer of a packed-BCD value: the lowest min(value,10) LEDs lit.
    // Any non-zero tens digit means at least 10, so every LED is lit.
    function automatic logic [9:0] bcd_therm(input logic [7:0] bcd);
        logic [9:0] t;
        if (bcd[7:4] != 4'd0) begin
            t = LEDR_ALL;
        end else begin
            t = ~(LEDR_ALL << bcd[3:0]);
        end
        return t;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit packed BCD counter, saturating at 00 and 99
//
// Ports:
//   clk       in   1  clock, rising edge
//   resetn    in   1  asynchronous active-low reset (value -> RESET_VAL)
//   clr       in   1  force value to 00 (highest priority)
//   load      in   1  load load_val
//   load_val  in   8  packed BCD {tens,ones} to load
//   inc       in   1  count up by one, holds at 99
//   dec       in   1  count down by one, holds at 00
//   value     out  8  current packed BCD value
//   zero      out  1  value is 00
module bcd2_counter #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] value,
    output logic       zero
);

    logic [7:0] next_value;

    always_comb begin
        next_value = value;
        if (clr) begin
            next_value = 8'h00;
        end else if (load) begin
            next_value = load_val;
        end else if (inc && !dec) begin
            if (value == 8'h99) begin
                next_value = value;
            end else if (value[3:0] == 4'd9) begin
                next_value = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next_value = {value[7:4], value[3:0] + 4'd1};
            end
        end else if (dec && !inc) begin
            if (value == 8'h00) begin
                next_value = value;
            end else if (value[3:0] == 4'd0) begin
                next_value = {value[7:4] - 4'd1, 4'd9};
            end else begin
                next_value = {value[7:4], value[3:0] - 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= RESET_VAL;
        end else begin
            value <= next_value;
        end
    end

    assign zero = (value == 8'h00);

endmodule

// File: rtl/game_status_formatter.sv
// rtl/game_status_formatter.sv - game mode / BCD countdown / BCD score tracker feeding the board display holders
//
// Parameters:
//   CLK_HZ      clock cycles per one-second tick
//   TIME_START  countdown start value, packed BCD 01..99
// Optional build macro:
//   GAMEDISP_BLINK_EN  in OVER, LEDR blinks all-on/all-off every half second instead of showing the score
// Ports:
//   CLOCK_50     in   1  system clock
//   resetn       in   1  asynchronous active-low reset
//   ingameOn     in   1  level: game in progress
//   gameOver     in   1  level: game finished by game logic
//   userquit     in   1  level: player abandoned game
//   match_pulse  in   1  one-cycle strobe: a tile pair was matched
//   time_up      out  1  one-cycle strobe when the countdown reaches 00
//   hex0hldr     out  4  mode code
//   hex2hldr     out  4  score ones
//   hex3hldr     out  4  score tens (blank when zero)
//   hex4hldr     out  4  timer ones
//   hex5hldr     out  4  timer tens
//   ledrhldr     out 10  score thermometer / end-of-game pattern
module game_status_formatter
    import game_pkg::*;
#(
    parameter int         CLK_HZ     = 50_000_000,
    parameter logic [7:0] TIME_START = 8'h60
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       ingameOn,
    input  logic       gameOver,
    input  logic       userquit,
    input  logic       match_pulse,
    output logic       time_up,
    output logic [3:0] hex0hldr,
    output logic [3:0] hex2hldr,
    output logic [3:0] hex3hldr,
    output logic [3:0] hex4hldr,
    output logic [3:0] hex5hldr,
    output logic [9:0] ledrhldr
);

    localparam int               PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    state_t           state;
    state_t           state_next;
    logic [PRE_W-1:0] presc;
    logic             in_play;
    logic             tick;
    logic             start_game;
    logic [7:0]       timer_val;
    logic [7:0]       score_val;
    logic             timer_zero;
    logic             score_zero;
    logic [3:0]       score_tens_disp;
    logic [9:0]       score_therm;
    logic [9:0]       over_ledr;

    assign in_play    = (state == ST_PLAY);
    assign tick       = in_play && (presc == PRE_LAST);
    assign start_game = (state == ST_IDLE) && (state_next == ST_PLAY);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // userquit outranks gameOver/time_up, which outrank ingameOn
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (userquit)                    state_next = ST_QUIT;
                else if (ingameOn && !gameOver)  state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (userquit)                    state_next = ST_QUIT;
                else if (gameOver || time_up)    state_next = ST_OVER;
                else if (!ingameOn)              state_next = ST_IDLE;
            end
            ST_OVER: begin
                if (userquit)                    state_next = ST_QUIT;
                else if (!ingameOn && !gameOver) state_next = ST_IDLE;
            end
            ST_QUIT: begin
                if (!userquit)                   state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- prescaler
    // Held at zero outside PLAY so every game starts a full second from its first tick.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
        end else if (!in_play || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    // ---------------------------------------------------------- counters
    bcd2_counter #(
        .RESET_VAL (TIME_START)
    ) u_timer (
        .clk      (CLOCK_50),
        .resetn   (resetn),
        .clr      (1'b0),
        .load     (start_game),
        .load_val (TIME_START),
        .inc      (1'b0),
        .dec      (tick && !timer_zero),
        .value    (timer_val),
        .zero     (timer_zero)
    );

    bcd2_counter #(
        .RESET_VAL (8'h00)
    ) u_score (
        .clk      (CLOCK_50),
        .resetn   (resetn),
        .clr      (start_game),
        .load     (1'b0),
        .load_val (8'h00),
        .inc      (in_play && match_pulse),
        .dec      (1'b0),
        .value    (score_val),
        .zero     (score_zero)
    );

    // Strobe on the same edge the timer steps 01 -> 00; the FSM sees it one cycle later.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            time_up <= 1'b0;
        end else begin
            time_up <= tick && (timer_val == 8'h01);
        end
    end

    // ---------------------------------------------------------- display
    assign score_tens_disp = (score_val[7:4] == 4'd0) ? DIG_BLANK : score_val[7:4];
    assign score_therm     = score_zero ? 10'h000 : bcd_therm(score_val);

`ifdef GAMEDISP_BLINK_EN
    localparam int              HALF      = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
    localparam int              HALF_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

    logic [HALF_W-1:0] half_cnt;
    logic              blink_on;

    // Parked at "on" outside OVER so the pattern always opens with all LEDs lit.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            half_cnt <= '0;
            blink_on <= 1'b1;
        end else if (state != ST_OVER) begin
            half_cnt <= '0;
            blink_on <= 1'b1;
        end else if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            blink_on <= ~blink_on;
        end else begin
            half_cnt <= half_cnt + HALF_W'(1);
        end
    end

    assign over_ledr = {10{blink_on}};
`else
    assign over_ledr = score_therm;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            hex0hldr <= MODE_IDLE;
            hex2hldr <= DIG_BLANK;
            hex3hldr <= DIG_BLANK;
            hex4hldr <= DIG_BLANK;
            hex5hldr <= DIG_BLANK;
            ledrhldr <= 10'h000;
        end else begin
            case (state)
                ST_PLAY: begin
                    hex0hldr <= MODE_PLAY;
                    hex2hldr <= score_val[3:0];
                    hex3hldr <= score_tens_disp;
                    hex4hldr <= timer_val[3:0];
                    hex5hldr <= timer_val[7:4];
                    ledrhldr <= score_therm;
                end
                ST_OVER: begin
                    hex0hldr <= MODE_OVER;
                    hex2hldr <= score_val[3:0];
                    hex3hldr <= score_tens_disp;
                    hex4hldr <= DIG_BLANK;
                    hex5hldr <= DIG_BLANK;
                    ledrhldr <= over_ledr;
                end
                ST_QUIT: begin
                    hex0hldr <= MODE_QUIT;
                    hex2hldr <= DIG_BLANK;
                    hex3hldr <= DIG_BLANK;
                    hex4hldr <= DIG_BLANK;
                    hex5hldr <= DIG_BLANK;
                    ledrhldr <= 10'h000;
                end
                default: begin
                    hex0hldr <= MODE_IDLE;
                    hex2hldr <= DIG_BLANK;
                    hex3hldr <= DIG_BLANK;
                    hex4hldr <= DIG_BLANK;
                    hex5hldr <= DIG_BLANK;
                    ledrhldr <= 10'h000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_status_formatter.sv
// tb/tb_game_status_formatter.sv - self-checking bench for game_status_formatter
`timescale 1ns/1ps
module tb_game_status_formatter;

    localparam int CLK_HZ = 4;
    localparam int T0     = 3;
    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_OVER = 2;
    localparam int S_QUIT = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ingameOn = 1'b0;
    logic       gameOver = 1'b0;
    logic       userquit = 1'b0;
    logic       match_pulse = 1'b0;

    logic       time_up;
    logic [3:0] hex0, hex2, hex3, hex4, hex5;
    logic [9:0] ledr;
    logic       b_time_up;
    logic [3:0] b_hex0, b_hex2, b_hex3, b_hex4, b_hex5;
    logic [9:0] b_ledr;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    game_status_formatter #(.CLK_HZ(CLK_HZ), .TIME_START(8'h03)) dut (
        .CLOCK_50(clk), .resetn(resetn), .ingameOn(ingameOn), .gameOver(gameOver),
        .userquit(userquit), .match_pulse(match_pulse), .time_up(time_up),
        .hex0hldr(hex0), .hex2hldr(hex2), .hex3hldr(hex3), .hex4hldr(hex4),
        .hex5hldr(hex5), .ledrhldr(ledr)
    );

    // Long countdown instance so a single game can run long enough to reach a score of 99
    game_status_formatter #(.CLK_HZ(CLK_HZ), .TIME_START(8'h99)) dut_long (
        .CLOCK_50(clk), .resetn(resetn), .ingameOn(ingameOn), .gameOver(gameOver),
        .userquit(userquit), .match_pulse(match_pulse), .time_up(b_time_up),
        .hex0hldr(b_hex0), .hex2hldr(b_hex2), .hex3hldr(b_hex3), .hex4hldr(b_hex4),
        .hex5hldr(b_hex5), .ledrhldr(b_ledr)
    );

    // ------------------------------------------------ reference model (plain integers)
    typedef struct {
        int         st;
        int         presc;
        int         timer;
        int         score;
        int         age;
        logic       tu;
        logic [3:0] h0, h2, h3, h4, h5;
        logic [9:0] ledr;
    } model_t;

    function automatic logic [9:0] therm(input int s);
        int n;
        n = (s > 10) ? 10 : s;
        return 10'((1 << n) - 1);
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.st = S_IDLE; m.presc = 0; m.timer = T0; m.score = 0; m.age = 0; m.tu = 1'b0;
        m.h0 = 4'h0; m.h2 = 4'hF; m.h3 = 4'hF; m.h4 = 4'hF; m.h5 = 4'hF; m.ledr = 10'h000;
        return m;
    endfunction

    function automatic model_t model_next(input model_t m, input logic ig, input logic go,
                                          input logic uq, input logic mp);
        model_t n;
        logic   tick;
        n = m;
        tick = (m.st == S_PLAY) && (m.presc == CLK_HZ - 1);
        // holders show the situation as it stood before this edge
        n.h2 = 4'(m.score % 10);
        n.h3 = (m.score < 10) ? 4'hF : 4'(m.score / 10);
        case (m.st)
            S_PLAY: begin
                n.h0 = 4'h1; n.h4 = 4'(m.timer % 10); n.h5 = 4'(m.timer / 10);
                n.ledr = therm(m.score);
            end
            S_OVER: begin
                n.h0 = 4'hE; n.h4 = 4'hF; n.h5 = 4'hF;
`ifdef GAMEDISP_BLINK_EN
                n.ledr = (((m.age / (CLK_HZ / 2)) % 2) == 0) ? 10'h3FF : 10'h000;
`else
                n.ledr = therm(m.score);
`endif
            end
            S_QUIT: begin
                n.h0 = 4'hC; n.h2 = 4'hF; n.h3 = 4'hF; n.h4 = 4'hF; n.h5 = 4'hF; n.ledr = 10'h000;
            end
            default: begin
                n.h0 = 4'h0; n.h2 = 4'hF; n.h3 = 4'hF; n.h4 = 4'hF; n.h5 = 4'hF; n.ledr = 10'h000;
            end
        endcase
        case (m.st)
            S_IDLE: if (uq) n.st = S_QUIT; else if (ig && !go) n.st = S_PLAY;
            S_PLAY: if (uq) n.st = S_QUIT; else if (go || m.tu) n.st = S_OVER; else if (!ig) n.st = S_IDLE;
            S_OVER: if (uq) n.st = S_QUIT; else if (!ig && !go) n.st = S_IDLE;
            default: if (!uq) n.st = S_IDLE;
        endcase
        n.tu = tick && (m.timer == 1);
        if (m.st == S_IDLE && n.st == S_PLAY) begin
            n.score = 0;
            n.timer = T0;
        end else if (m.st == S_PLAY) begin
            if (mp && m.score < 99) n.score = m.score + 1;
            if (tick && m.timer > 0) n.timer = m.timer - 1;
        end
        n.presc = (m.st == S_PLAY && !tick) ? m.presc + 1 : 0;
        n.age   = (m.st == S_OVER && n.st == S_OVER) ? m.age + 1 : 0;
        return n;
    endfunction

    model_t mdl;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) mdl <= model_reset();
        else         mdl <= model_next(mdl, ingameOn, gameOver, userquit, match_pulse);
    end

    logic [30:0] dut_vec;
    logic [30:0] exp_vec;
    assign dut_vec = {time_up, hex0, hex2, hex3, hex4, hex5, ledr};
    assign exp_vec = {mdl.tu, mdl.h0, mdl.h2, mdl.h3, mdl.h4, mdl.h5, mdl.ledr};

    // ------------------------------------------------ scenarios
    task automatic test_reset();
        resetn = 1'b0; ingameOn = 1'b0; gameOver = 1'b0; userquit = 1'b0; match_pulse = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if ({hex0, hex2, hex3, hex4, hex5} !== 20'h0FFFF) $display("FAIL reset_digits got=%h exp=0ffff", {hex0, hex2, hex3, hex4, hex5});
        else passed++;
        total++;
        if (ledr !== 10'h000) $display("FAIL reset_ledr got=%h exp=000", ledr); else passed++;
        total++;
        if (time_up !== 1'b0) $display("FAIL reset_time_up got=%b exp=0", time_up); else passed++;
        total++;
        if (dut_vec !== exp_vec) $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec); else passed++;
    endtask

    task automatic test_countdown();
        int tu_count = 0;
        int tu_cycle = -1;
        ingameOn = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (time_up === 1'b1) begin tu_count++; tu_cycle = c; end
            total++;
            if (dut_vec !== exp_vec) $display("FAIL countdown_model cycle %0d got=%h exp=%h", c, dut_vec, exp_vec); else passed++;
            if (c == 2 || c == 6 || c == 10 || c == 14) begin
                total++;
                if ({hex0, hex5, hex4} !== {4'h1, 8'(T0 - (c - 2) / 4)})
                    $display("FAIL countdown_timer cycle %0d got=%h exp=%h", c, {hex0, hex5, hex4}, {4'h1, 8'(T0 - (c - 2) / 4)});
                else passed++;
            end
            if (c == 15) begin
                total++;
                if ({hex0, hex5, hex4} !== 12'hEFF) $display("FAIL countdown_over got=%h exp=eff", {hex0, hex5, hex4}); else passed++;
            end
        end
        total++;
        if (tu_count !== 1 || tu_cycle !== 13) $display("FAIL time_up_pulse got=%0d@%0d exp=1@13", tu_count, tu_cycle); else passed++;
        ingameOn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (hex0 !== 4'h0) $display("FAIL over_to_idle got=%h exp=0", hex0); else passed++;
    endtask

    task automatic test_score();
        ingameOn = 1'b1;
        @(negedge clk);
        match_pulse = 1'b1;
        repeat (12) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) $display("FAIL score_model got=%h exp=%h", dut_vec, exp_vec); else passed++;
        end
        match_pulse = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({hex0, hex3, hex2, ledr} !== {12'hE12, 10'h3FF}) $display("FAIL score_12 got=%h exp=%h", {hex0, hex3, hex2, ledr}, {12'hE12, 10'h3FF}); else passed++;
        ingameOn = 1'b0;
        repeat (2) @(negedge clk);
        ingameOn = 1'b1;
        @(negedge clk);
        match_pulse = 1'b1;
        repeat (3) @(negedge clk);
        match_pulse = 1'b0;
        @(negedge clk);
        total++;
        if ({hex0, hex3, hex2, ledr} !== {12'h1F3, 10'h007}) $display("FAIL score_3 got=%h exp=%h", {hex0, hex3, hex2, ledr}, {12'h1F3, 10'h007}); else passed++;
        ingameOn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tick_coincide();
        ingameOn = 1'b1;
        @(negedge clk);
        match_pulse = 1'b1;
        repeat (4) @(negedge clk);
        match_pulse = 1'b0;
        @(negedge clk);
        total++;
        if ({hex3, hex2, hex5, hex4, ledr} !== {16'hF402, 10'h00F}) $display("FAIL tick_and_match got=%h exp=%h", {hex3, hex2, hex5, hex4, ledr}, {16'hF402, 10'h00F}); else passed++;
        ingameOn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_saturation();
        ingameOn = 1'b1;
        @(negedge clk);
        match_pulse = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 100) begin
                total++;
                if ({b_hex3, b_hex2} !== 8'h99) $display("FAIL score_reach_99 got=%h exp=99", {b_hex3, b_hex2}); else passed++;
            end
        end
        match_pulse = 1'b0;
        @(negedge clk);
        total++;
        if ({b_hex0, b_hex3, b_hex2, b_ledr} !== {12'h199, 10'h3FF}) $display("FAIL score_saturate got=%h exp=%h", {b_hex0, b_hex3, b_hex2, b_ledr}, {12'h199, 10'h3FF}); else passed++;
        total++;
        if ({b_hex5, b_hex4} !== 8'h74) $display("FAIL long_timer got=%h exp=74", {b_hex5, b_hex4}); else passed++;
        ingameOn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_quit();
        ingameOn = 1'b1;
        repeat (3) @(negedge clk);
        userquit = 1'b1;
        gameOver = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({hex0, hex2, hex3, hex4, hex5, ledr} !== {20'hCFFFF, 10'h000}) $display("FAIL quit_priority got=%h exp=%h", {hex0, hex2, hex3, hex4, hex5, ledr}, {20'hCFFFF, 10'h000}); else passed++;
        userquit = 1'b0;
        gameOver = 1'b0;
        ingameOn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (hex0 !== 4'h0) $display("FAIL quit_to_idle got=%h exp=0", hex0); else passed++;
    endtask

    task automatic test_reset_midgame();
        ingameOn = 1'b1;
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({time_up, hex0, hex2, hex3, hex4, hex5, ledr} !== {1'b0, 20'h0FFFF, 10'h000})
            $display("FAIL async_reset got=%h exp=%h", {time_up, hex0, hex2, hex3, hex4, hex5, ledr}, {1'b0, 20'h0FFFF, 10'h000});
        else passed++;
        ingameOn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (time_up !== 1'b0 || dut_vec !== exp_vec) $display("FAIL post_reset cycle %0d got=%h exp=%h", c, dut_vec, exp_vec); else passed++;
        end
    endtask

    task automatic test_random();
        ingameOn = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) ingameOn = ~ingameOn;
            gameOver    = ($urandom_range(0, 29) == 0);
            userquit    = ($urandom_range(0, 59) == 0) ? 1'b1 : (userquit && ($urandom_range(0, 2) != 0));
            match_pulse = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) $display("FAIL random cycle %0d got=%h exp=%h", i, dut_vec, exp_vec); else passed++;
        end
        ingameOn = 1'b0; gameOver = 1'b0; userquit = 1'b0; match_pulse = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_score();
        test_tick_coincide();
        test_saturation();
        test_quit();
        test_reset_midgame();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
